// File: rtl/sobel_pkg.sv
// Shared constants and per-beat position tag for the Sobel magnitude pipeline.
package sobel_pkg;

    localparam int unsigned WIDTH_D  = 8;
    localparam int unsigned DEPTH_D  = 16;
    localparam int unsigned HEIGHT_D = 16;
    localparam int unsigned POS_W    = 16;

    typedef struct packed {
        logic [POS_W-1:0] col;
        logic [POS_W-1:0] row;
        logic             eof;
    } beat_tag_t;

endpackage

// File: rtl/elastic_stage.sv
// Valid/ready register slice: loads whenever empty or when downstream takes the held beat.
module elastic_stage #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/sobel_magnitude.sv
// Three-stage elastic pipeline turning Sobel gradients into a saturated,
// border-masked magnitude with edge flag and end-of-frame marker.
module sobel_magnitude
    import sobel_pkg::*;
#(
    parameter int unsigned WIDTH_P  = WIDTH_D,
    parameter int unsigned DEPTH_P  = DEPTH_D,
    parameter int unsigned HEIGHT_P = HEIGHT_D
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic signed [2*WIDTH_P-1:0] gx_i,
    input  logic signed [2*WIDTH_P-1:0] gy_i,
    input  logic        [WIDTH_P-1:0]   thresh_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic        [WIDTH_P-1:0]   mag_o,
    output logic                        edge_o,
    output logic                        eof_o
);

    localparam int unsigned GW = 2 * WIDTH_P;
    localparam logic [POS_W-1:0] LAST_COL = POS_W'(DEPTH_P - 1);
    localparam logic [POS_W-1:0] LAST_ROW = POS_W'(HEIGHT_P - 1);

    typedef struct packed {
        logic [GW-1:0]      abs_x;
        logic [GW-1:0]      abs_y;
        logic [WIDTH_P-1:0] thresh;
        beat_tag_t          tag;
    } s1_t;

    typedef struct packed {
        logic [GW:0]        sum;
        logic [WIDTH_P-1:0] thresh;
        beat_tag_t          tag;
    } s2_t;

    typedef struct packed {
        logic [WIDTH_P-1:0] mag;
        logic               edge_hit;
        logic               eof;
    } s3_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;
    logic v1, v2;
    logic rdy2, rdy3;

    logic [POS_W-1:0] col_q, row_q;
    logic             accept;
    logic             last_col, last_row;

    assign accept   = valid_i && ready_o;
    assign last_col = (col_q == LAST_COL);
    assign last_row = (row_q == LAST_ROW);

    // Position is tagged at acceptance, so downstream stalls never shift it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= last_row ? '0 : row_q + POS_W'(1);
            end else begin
                col_q <= col_q + POS_W'(1);
            end
        end
    end

    // Negating in GW unsigned bits maps the most negative input to 2^(GW-1).
    always_comb begin
        s1_d.abs_x   = gx_i[GW-1] ? $unsigned(-gx_i) : $unsigned(gx_i);
        s1_d.abs_y   = gy_i[GW-1] ? $unsigned(-gy_i) : $unsigned(gy_i);
        s1_d.thresh  = thresh_i;
        s1_d.tag.col = col_q;
        s1_d.tag.row = row_q;
        s1_d.tag.eof = last_col && last_row;
    end

    always_comb begin
        s2_d.sum    = {1'b0, s1_q.abs_x} + {1'b0, s1_q.abs_y};
        s2_d.thresh = s1_q.thresh;
        s2_d.tag    = s1_q.tag;
    end

    logic [WIDTH_P-1:0] mag_sat;
    logic               border;

    always_comb begin
        mag_sat     = (|s2_q.sum[GW:WIDTH_P]) ? '1 : s2_q.sum[WIDTH_P-1:0];
        border      = (s2_q.tag.col < POS_W'(2)) || (s2_q.tag.row < POS_W'(2));
        s3_d.mag      = border ? '0 : mag_sat;
        s3_d.edge_hit = !border && (mag_sat > s2_q.thresh);
        s3_d.eof      = s2_q.tag.eof;
    end

    elastic_stage #(.DATA_W($bits(s1_t))) u_stage1 (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .in_valid (valid_i),
        .in_ready (ready_o),
        .in_data  (s1_d),
        .out_valid(v1),
        .out_ready(rdy2),
        .out_data (s1_q)
    );

    elastic_stage #(.DATA_W($bits(s2_t))) u_stage2 (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .in_valid (v1),
        .in_ready (rdy2),
        .in_data  (s2_d),
        .out_valid(v2),
        .out_ready(rdy3),
        .out_data (s2_q)
    );

    elastic_stage #(.DATA_W($bits(s3_t))) u_stage3 (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .in_valid (v2),
        .in_ready (rdy3),
        .in_data  (s3_d),
        .out_valid(valid_o),
        .out_ready(ready_i),
        .out_data (s3_q)
    );

    assign mag_o  = s3_q.mag;
    assign edge_o = s3_q.edge_hit;
    assign eof_o  = s3_q.eof;

endmodule

// File: tb/tb_sobel_magnitude.sv
// Randomised and directed bench for sobel_magnitude against a positional
// arithmetic reference model with a scoreboard queue.
module tb_sobel_magnitude;

    localparam int W = 8;
    localparam int D = 16;
    localparam int H = 16;

    logic                  clk, rstn_i;
    logic                  valid_i, ready_o, valid_o, ready_i;
    logic signed [2*W-1:0] gx_i, gy_i;
    logic        [W-1:0]   thresh_i, mag_o;
    logic                  edge_o, eof_o;

    sobel_magnitude #(.WIDTH_P(W), .DEPTH_P(D), .HEIGHT_P(H)) dut (
        .clk_i   (clk),
        .rstn_i  (rstn_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .gx_i    (gx_i),
        .gy_i    (gy_i),
        .thresh_i(thresh_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .mag_o   (mag_o),
        .edge_o  (edge_o),
        .eof_o   (eof_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int mag;
        int edge_v;
        int eof;
        int cyc;
    } exp_t;

    exp_t expq[$];
    int   qa[$], qb[$];
    int   rec_sel = 0;
    int   m_col = 0, m_row = 0;
    bit   chk_lat = 1'b1, stall_en = 1'b0;
    int   n_checks = 0, n_pass = 0;
    int   last_mag = -1, last_edge = -1, last_eof = -1;
    int   n_out = 0, n_zero = 0, n_hundred = 0, eof_cnt = 0, eof_idx = 0;
    int   rgx[256], rgy[256], rthr[256];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference: plain integer arithmetic on the position the beat occupies in the frame.
    task automatic model_push(input int gx, input int gy, input int thr);
        exp_t e;
        int   s, sat;
        bit   border;
        s      = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        sat    = (s > 255) ? 255 : s;
        border = (m_col < 2) || (m_row < 2);
        e.mag    = border ? 0 : sat;
        e.edge_v = border ? 0 : int'(sat > thr);
        e.eof    = int'(m_col == D - 1 && m_row == H - 1);
        e.cyc    = cyc;
        expq.push_back(e);
        m_col++;
        if (m_col == D) begin
            m_col = 0;
            m_row++;
            if (m_row == H) m_row = 0;
        end
    endtask

    task automatic send(input int gx, input int gy, input int thr);
        int waited = 0;
        valid_i  = 1'b1;
        gx_i     = 16'(gx);
        gy_i     = 16'(gy);
        thresh_i = 8'(thr);
        @(negedge clk);
        while (!ready_o && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_o) begin
            check_eq("accept_timeout", 0, 1);
        end else begin
            model_push(gx, gy, thr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int waited = 0;
        valid_i = 1'b0;
        while (expq.size() != 0 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (expq.size() != 0) check_eq("drain_timeout", expq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (stall_en) begin
            #1;
            ready_i = 1'($urandom_range(0, 1));
        end
    end

    logic [W-1:0] h_mag;
    logic         h_edge, h_eof;
    bit           h_stall = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rstn_i) begin
            h_stall = 1'b0;
        end else begin
            if (h_stall) begin
                check_eq("stall_valid", int'(valid_o), 1);
                check_eq("stall_mag", int'(mag_o), int'(h_mag));
                check_eq("stall_edge", int'(edge_o), int'(h_edge));
                check_eq("stall_eof", int'(eof_o), int'(h_eof));
            end
            if (valid_o && ready_i) begin
                if (expq.size() == 0) begin
                    check_eq("spurious_out", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check_eq("mag", int'(mag_o), e.mag);
                    check_eq("edge", int'(edge_o), e.edge_v);
                    check_eq("eof", int'(eof_o), e.eof);
                    if (chk_lat) check_eq("latency", cyc - e.cyc, 3);
                    last_mag  = int'(mag_o);
                    last_edge = int'(edge_o);
                    last_eof  = int'(eof_o);
                    n_out++;
                    if (mag_o == 8'd0) n_zero++;
                    else if (mag_o == 8'd100) n_hundred++;
                    if (eof_o) begin
                        eof_cnt++;
                        eof_idx = n_out;
                    end
                    if (rec_sel == 1) qa.push_back({mag_o, edge_o, eof_o});
                    if (rec_sel == 2) qb.push_back({mag_o, edge_o, eof_o});
                end
            end
            h_stall = valid_o && !ready_i;
            h_mag   = mag_o;
            h_edge  = edge_o;
            h_eof   = eof_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        rstn_i   = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        gx_i     = '0;
        gy_i     = '0;
        thresh_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid_o", int'(valid_o), 0);
        check_eq("rst_mag_o", int'(mag_o), 0);
        check_eq("rst_edge_o", int'(edge_o), 0);
        check_eq("rst_eof_o", int'(eof_o), 0);
        @(negedge clk);
        rstn_i = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_rst", int'(ready_o), 1);

        // Directed beats at row 5: column 5, 6, 7, 8.
        repeat (5 * D + 5) send(0, 0, 0);
        send(3, -4, 5);
        drain();
        check_eq("d_3_m4_mag", last_mag, 7);
        check_eq("d_3_m4_edge", last_edge, 1);
        send(-32768, -32768, 254);
        drain();
        check_eq("d_neg_max_mag", last_mag, 255);
        check_eq("d_neg_max_edge", last_edge, 1);
        send(10, 0, 10);
        drain();
        check_eq("d_eq_thr_mag", last_mag, 10);
        check_eq("d_eq_thr_edge", last_edge, 0);
        send(128, 128, 255);
        drain();
        check_eq("d_sat256_mag", last_mag, 255);
        check_eq("d_sat256_edge", last_edge, 0);

        // Full frame of gx=100 starting at column 0 row 0.
        while (!(m_col == 0 && m_row == 0)) send(0, 0, 0);
        drain();
        n_out = 0; n_zero = 0; n_hundred = 0; eof_cnt = 0; eof_idx = 0;
        repeat (D * H) send(100, 0, 50);
        drain();
        check_eq("frame_beats", n_out, 256);
        check_eq("frame_border_zero", n_zero, 60);
        check_eq("frame_interior_100", n_hundred, 196);
        check_eq("frame_eof_count", eof_cnt, 1);
        check_eq("frame_eof_index", eof_idx, 256);

        // Same random frame without and with downstream stalls.
        for (int i = 0; i < 256; i++) begin
            rgx[i]  = int'($urandom_range(0, 65535)) - 32768;
            rgy[i]  = int'($urandom_range(0, 511)) - 256;
            rthr[i] = int'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) rgx[i] = -32768;
        end
        rec_sel = 1;
        for (int i = 0; i < 256; i++) send(rgx[i], rgy[i], rthr[i]);
        drain();
        rec_sel  = 2;
        chk_lat  = 1'b0;
        stall_en = 1'b1;
        for (int i = 0; i < 256; i++) send(rgx[i], rgy[i], rthr[i]);
        valid_i  = 1'b0;
        stall_en = 1'b0;
        @(posedge clk);
        #2;
        ready_i = 1'b1;
        drain();
        chk_lat = 1'b1;
        rec_sel = 0;
        check_eq("stall_run_len", qb.size(), qa.size());
        for (int i = 0; i < 256; i++) begin
            if (i < qa.size() && i < qb.size()) check_eq("stall_vs_nostall", qb[i], qa[i]);
        end

        // Reset with three beats in flight, mid-row.
        repeat (5) send(100, 0, 50);
        drain();
        send(100, 0, 50);
        send(100, 0, 50);
        send(100, 0, 50);
        valid_i = 1'b0;
        rstn_i  = 1'b0;
        #1;
        check_eq("midrst_valid_o", int'(valid_o), 0);
        check_eq("midrst_mag_o", int'(mag_o), 0);
        expq.delete();
        m_col = 0;
        m_row = 0;
        @(negedge clk);
        rstn_i = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_ready", int'(ready_o), 1);
        send(100, 0, 50);
        drain();
        check_eq("midrst_first_mag", last_mag, 0);
        repeat (2 * D + 1) send(100, 0, 50);
        send(100, 0, 50);
        drain();
        check_eq("midrst_c2r2_mag", last_mag, 100);
        check_eq("midrst_c2r2_edge", last_edge, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
